qspi_sram_master: RTL
=====================

# qspi_sram_master

Byte-wide QSPI master that sits between the Levenshtein engine's memory port and the external PMOD QSPI SRAM pins. It accepts single-byte read/write requests over a valid/ready handshake and serialises each into one SQI-mode SRAM transaction: command, 24-bit address, optional dummy, data. Outputs map directly onto the `uio` SRAM pins: `ss_n`, `sck`, and four bidirectional `sio` lines with per-line output enables.

## Interface
Parameters:
- `ADDR_WIDTH`, 17, request address width; zero-extended to 24 bits on the wire (1 ≤ ADDR_WIDTH ≤ 24).
- `DUMMY_NIBBLES`, 2, dummy SCK cycles between read address and read data (even, ≥ 2).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle pulse; read data valid.
- `rsp_rdata`  out  8  read data; holds its value until the next read.
- `ss_n`  out  1  SRAM chip select, active low.
- `sck`  out  1  SRAM clock, clk/2 while active.
- `sio_out`  out  4  data to SRAM.
- `sio_oe`  out  4  per-line output enable.
- `sio_in`  in  4  data from SRAM.

## Operation
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `ss_n`=1, `sck`=0, `sio_out`=0, `sio_oe`=0.
- States: INIT (macro only), IDLE, CMD, ADDR, DUMMY, DATA_WR, DATA_RD, DONE.
- IDLE: `req_ready`=1. On acceptance, latch write, address, data and go to CMD. `req_ready`=0 in every other state.
- CMD: 2 nibbles, MSB first. Write = 8'h02, read = 8'h03.
- ADDR: 6 nibbles of the zero-extended 24-bit address, MSB first. Then write → DATA_WR; read → DUMMY.
- DUMMY: `DUMMY_NIBBLES` SCK cycles with `sio_oe`=0.
- DATA_WR: 2 nibbles, high nibble first.
- DATA_RD: capture 2 nibbles from `sio_in`, high nibble first.
- `sio_oe` is 4'hF in CMD, ADDR and DATA_WR, and 0 in DUMMY and DATA_RD.
- DONE: `ss_n`=1 for one cycle, then IDLE.
- Writes produce no response. Each read produces exactly one `rsp_valid` pulse.
- A new request arriving while busy is held off by `req_ready`=0. The requester keeps its request stable until it is accepted.
- Reset mid-transaction: next cycle is the reset state. The transaction is dropped, no `rsp_valid` is produced, and INIT reruns if compiled in.

## Timing
- Cycle 0 is the acceptance edge. `ss_n` is 0 from cycle 1 through the final SCK-high cycle.
- Nibble k is driven in cycle 1+2k with `sck`=0. `sck`=1 in cycle 2+2k.
- Read nibbles are sampled on the edge that ends the `sck`=1 cycle.
- Write:
  - 10 nibbles; last SCK high in cycle 20.
  - `ss_n`=1 in cycle 21; `req_ready`=1 in cycle 22.
  - Back-to-back throughput: 22 cycles per write.
- Read (DUMMY_NIBBLES=2):
  - 12 nibbles; last sample at the end of cycle 24.
  - `rsp_valid`=1 and `rsp_rdata` updated in cycle 25, coincident with `ss_n`=1.
  - `req_ready`=1 in cycle 26.
  - General latency: acceptance to `rsp_valid` = 2·(10+DUMMY_NIBBLES)+1 cycles.
- `sck` never toggles while `ss_n`=1. `sck` is 0 whenever `ss_n` rises or falls.

## Configuration
- `QSPI_SRAM_INIT_EN` defined:
  - After reset the block enters INIT and sends EQIO (8'h38) in SPI mode: MSB first on `sio_out[0]`, `sio_oe`=4'b0001, 8 SCK cycles.
  - `ss_n` low in cycles 1–16 after reset release, high in cycle 17, then IDLE with `req_ready`=1 in cycle 18.
- Undefined:
  - The block resets directly into IDLE, and `req_ready`=1 in the first cycle after reset release.
  - The SRAM is assumed to be in SQI mode already.

## Structure
- Shared package `qspi_sram_pkg` holds:
  - `CMD_WRITE`=8'h02, `CMD_READ`=8'h03, `CMD_EQIO`=8'h38.
  - The state enum `qspi_state_t`.
  - `QSPI_ADDR_NIBBLES`=6.
- Single module with one FSM, a nibble counter and an 8-bit shift register. No sub-module is warranted.

## Test plan
- Reset with macro defined: `ss_n` low in cycles 1–16, `sio_out[0]` bitstream 0,0,1,1,1,0,0,0 on SCK rises, `req_ready` high at cycle 18. Without the macro, `req_ready` is high at cycle 1.
- Write addr 17'h1_2345, data 8'hA5: nibbles on `sio_out` are 0,2,0,1,2,3,4,5,A,5; `ss_n` low for cycles 1–20; `req_ready` back at cycle 22; no `rsp_valid`.
- Read addr 17'h0_00FF with the SRAM model returning 8'h3C: `sio_oe`=0 from DUMMY onward; `rsp_valid` pulse at cycle 25 with `rsp_rdata`=8'h3C.
- Write 8'h5A to 17'h1FFFF, then read it back, against the `qspi_sram` model: `rsp_rdata`=8'h5A. Also read at the top address 17'h1FFFF and check the wire address is 24'h01FFFF.
- `req_valid` held high for 3 back-to-back reads: accepted at cycles 0, 26, 52; exactly 3 `rsp_valid` pulses.
- Assert `rst` at cycle 10 of a read: `ss_n`=1, `sck`=0, `sio_oe`=0 the next cycle; no `rsp_valid`; clean restart afterwards.

Source files
------------

// File: rtl/qspi_sram_pkg.sv
// qspi_sram_pkg: SRAM command codes, address framing and FSM state encoding
// shared by the QSPI SRAM master.
package qspi_sram_pkg;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_EQIO  = 8'h38;
    localparam int QSPI_ADDR_NIBBLES = 6;
    typedef enum logic [2:0] {INIT, IDLE, CMD, ADDR, DUMMY, DATA_WR, DATA_RD, DONE} qspi_state_t;
endpackage

// File: rtl/qspi_sram_master.sv
// qspi_sram_master: serialises single-byte read/write requests into SQI-mode SRAM
// transactions. Define QSPI_SRAM_INIT_EN to send EQIO in SPI mode after reset.
module qspi_sram_master
    import qspi_sram_pkg::*;
#(
    parameter int ADDR_WIDTH    = 17,
    parameter int DUMMY_NIBBLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  ss_n,
    output logic                  sck,
    output logic [3:0]            sio_out,
    output logic [3:0]            sio_oe,
    input  logic [3:0]            sio_in
);
`ifdef QSPI_SRAM_INIT_EN
    localparam qspi_state_t RST_STATE = INIT;
`else
    localparam qspi_state_t RST_STATE = IDLE;
`endif

    qspi_state_t state, ns, nxt;
    logic [7:0]  cnt, ncnt, lst;
    logic [39:0] sh, nsh;
    logic        wr, nwr, nsck, nrv;
    logic [7:0]  nrd;
    logic [3:0]  noe, nout;

    // sh carries {cmd, addr, wdata} out of its top nibble and collects sio_in at the bottom
    always_comb begin
        ns   = state;
        ncnt = cnt;
        nsh  = sh;
        nwr  = wr;
        nsck = 1'b0;
        nrv  = 1'b0;
        nrd  = rsp_rdata;
        lst  = state == CMD   ? 8'd1 :
               state == ADDR  ? 8'(QSPI_ADDR_NIBBLES - 1) :
               state == DUMMY ? 8'(DUMMY_NIBBLES - 1) :
               state == INIT  ? 8'd7 : 8'd1;
        nxt  = state == CMD   ? ADDR :
               state == ADDR  ? (wr ? DATA_WR : DUMMY) :
               state == DUMMY ? DATA_RD : DONE;
        if (state == IDLE) begin
            if (req_valid && req_ready) begin
                ns   = CMD;
                nwr  = req_write;
                ncnt = '0;
                nsh  = {req_write ? CMD_WRITE : CMD_READ, 24'(req_addr), req_wdata};
            end
        end else if (state == DONE) begin
            ns = IDLE;
        end else if (ss_n) begin
            // first INIT cycle after reset: drop ss_n with sck held low
            nsck = 1'b0;
        end else if (!sck) begin
            nsck = 1'b1;
        end else begin
            nsh  = state == INIT ? {sh[38:0], 1'b0} : {sh[35:0], sio_in};
            ncnt = cnt == lst ? '0 : cnt + 8'd1;
            ns   = cnt == lst ? nxt : state;
            if (state == DATA_RD && cnt == lst) begin
                nrv = 1'b1;
                nrd = {sh[3:0], sio_in};
            end
        end
        noe  = (ns == CMD || ns == ADDR || ns == DATA_WR) ? 4'hF : ns == INIT ? 4'h1 : 4'h0;
        nout = ns == INIT ? {3'b000, nsh[39]} : noe[3] ? nsh[39:36] : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_STATE;
            cnt       <= '0;
            sh        <= {CMD_EQIO, 32'h0};
            wr        <= 1'b0;
            sck       <= 1'b0;
            ss_n      <= 1'b1;
            sio_oe    <= 4'h0;
            sio_out   <= 4'h0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= ns;
            cnt       <= ncnt;
            sh        <= nsh;
            wr        <= nwr;
            sck       <= nsck;
            ss_n      <= ns == IDLE || ns == DONE;
            sio_oe    <= noe;
            sio_out   <= nout;
            req_ready <= ns == IDLE;
            rsp_valid <= nrv;
            rsp_rdata <= nrd;
        end
    end
endmodule
